// File: rtl/UART_pkg.sv
// Shared UART-side constants: depths of the transmit and receive FIFOs
// instantiated by the user logic around sync_fifo_buffer.
package UART_pkg;

  localparam int TX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_DEPTH = 8;
  localparam int UART_DATA_WIDTH = 8;

endpackage

// File: rtl/sync_fifo_interface.sv
// Signal bundle for one sync_fifo_buffer; the clock stays outside so several
// FIFOs in one clock domain can share it.
interface sync_fifo_interface #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  write_i;
  logic                  read_i;
  logic                  rst_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  full_o;
  logic                  empty_o;

  modport fifo (
    input  wr_data_i, write_i, read_i, rst_i,
    output rd_data_o, full_o, empty_o
  );

  modport user (
    output wr_data_i, write_i, read_i, rst_i,
    input  rd_data_o, full_o, empty_o
  );

endinterface

// File: rtl/sync_fifo_buffer.sv
// Single-clock circular FIFO with wrap-bit pointers, selectable FWFT or registered
// read. Define SYNC_FIFO_COUNT_EN to add the count_o occupancy output.
module sync_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  write_i,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
`ifdef SYNC_FIFO_COUNT_EN
  output logic [$clog2(FIFO_DEPTH):0] count_o,
`endif
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic                  rd_en;
  logic                  wr_en;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  // A write into a full FIFO is still taken when a pop frees the slot on the same edge.
  assign rd_en = read_i && !empty_o;
  assign wr_en = write_i && (!full_o || rd_en);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_idx] <= wr_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Forced to zero while empty so reset shows rd_data_o = 0.
      assign rd_data_o = empty_o ? '0 : mem[rd_idx];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      rd_q <= '0;
        else if (rd_en) rd_q <= mem[rd_idx];
      end
      assign rd_data_o = rd_q;
    end
  endgenerate

`ifdef SYNC_FIFO_COUNT_EN
  assign count_o = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Bench for sync_fifo_buffer: one FWFT instance wired through sync_fifo_interface
// and one registered-read instance, both checked against queue-based models.
module tb_sync_fifo_buffer;
  import UART_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = RX_FIFO_DEPTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // FWFT instance through the interface
  sync_fifo_interface #(.DATA_WIDTH(DW)) f_if ();
  assign f_if.rst_i = rst;

  // registered-read instance on plain signals
  logic [DW-1:0] r_wr_data;
  logic          r_write;
  logic          r_read;
  logic [DW-1:0] r_rd_data;
  logic          r_full;
  logic          r_empty;

`ifdef SYNC_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] f_count;
  logic [$clog2(DEPTH):0] r_count;
`endif

  sync_fifo_buffer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk_i     (clk),
    .rst_i     (f_if.rst_i),
    .wr_data_i (f_if.wr_data_i),
    .write_i   (f_if.write_i),
    .read_i    (f_if.read_i),
    .rd_data_o (f_if.rd_data_o),
`ifdef SYNC_FIFO_COUNT_EN
    .count_o   (f_count),
`endif
    .full_o    (f_if.full_o),
    .empty_o   (f_if.empty_o)
  );

  sync_fifo_buffer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_reg (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_data_i (r_wr_data),
    .write_i   (r_write),
    .read_i    (r_read),
    .rd_data_o (r_rd_data),
`ifdef SYNC_FIFO_COUNT_EN
    .count_o   (r_count),
`endif
    .full_o    (r_full),
    .empty_o   (r_empty)
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rq[$];
  logic [DW-1:0] exp_rd;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_f_flags(input string tag);
    check({tag, "_empty"}, f_if.empty_o, exp_q.size() == 0);
    check({tag, "_full"},  f_if.full_o,  exp_q.size() == DEPTH);
`ifdef SYNC_FIFO_COUNT_EN
    check({tag, "_count"}, f_count, exp_q.size());
`endif
  endtask

  // driver: one clock of FWFT traffic; head is compared before the popping edge
  task automatic step_f(input logic w, input logic [DW-1:0] d, input logic r);
    bit rd_ok;
    bit wr_ok;
    rd_ok = r && (exp_q.size() > 0);
    wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
    if (rd_ok) check("f_head", f_if.rd_data_o, exp_q[0]);
    f_if.write_i   = w;
    f_if.wr_data_i = d;
    f_if.read_i    = r;
    @(posedge clk);
    #1;
    f_if.write_i = 1'b0;
    f_if.read_i  = 1'b0;
    if (rd_ok) void'(exp_q.pop_front());
    if (wr_ok) exp_q.push_back(d);
    check_f_flags("f_step");
  endtask

  // driver: one clock of registered-read traffic; data lands after the edge and holds
  task automatic step_r(input logic w, input logic [DW-1:0] d, input logic r);
    bit rd_ok;
    bit wr_ok;
    rd_ok = r && (exp_rq.size() > 0);
    wr_ok = w && ((exp_rq.size() < DEPTH) || rd_ok);
    r_write   = w;
    r_wr_data = d;
    r_read    = r;
    @(posedge clk);
    #1;
    r_write = 1'b0;
    r_read  = 1'b0;
    if (rd_ok) exp_rd = exp_rq.pop_front();
    if (wr_ok) exp_rq.push_back(d);
    check("r_data",  r_rd_data, exp_rd);
    check("r_empty", r_empty, exp_rq.size() == 0);
    check("r_full",  r_full,  exp_rq.size() == DEPTH);
  endtask

  initial begin
    f_if.write_i   = 1'b0;
    f_if.read_i    = 1'b0;
    f_if.wr_data_i = '0;
    r_write   = 1'b0;
    r_read    = 1'b0;
    r_wr_data = '0;
    exp_rd    = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_f_empty", f_if.empty_o, 1'b1);
    check("rst_f_full",  f_if.full_o, 1'b0);
    check("rst_f_data",  f_if.rd_data_o, 8'h00);
    check("rst_r_empty", r_empty, 1'b1);
    check("rst_r_data",  r_rd_data, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single word: still empty while the write is pending, visible right after its edge
    f_if.write_i   = 1'b1;
    f_if.wr_data_i = 8'hA5;
    #1;
    check("a5_pre_empty", f_if.empty_o, 1'b1);
    f_if.write_i = 1'b0;
    step_f(1'b1, 8'hA5, 1'b0);
    check("a5_data", f_if.rd_data_o, 8'hA5);
    step_f(1'b0, 8'h00, 1'b1);
    check("a5_popped_empty", f_if.empty_o, 1'b1);

    // fill to full, overflow attempt, drain in order
    for (int i = 1; i <= DEPTH; i++) step_f(1'b1, DW'(i), 1'b0);
    check("fill_full", f_if.full_o, 1'b1);
    step_f(1'b1, 8'hFF, 1'b0);
    check("ovf_full", f_if.full_o, 1'b1);
    for (int i = 0; i < DEPTH; i++) step_f(1'b0, 8'h00, 1'b1);
    check("drain_empty", f_if.empty_o, 1'b1);
    step_f(1'b0, 8'h00, 1'b1);

    // simultaneous write and read while full
    for (int i = 1; i <= DEPTH; i++) step_f(1'b1, DW'(i), 1'b0);
    step_f(1'b1, 8'h55, 1'b1);
    check("full_rw_full", f_if.full_o, 1'b1);
    for (int i = 0; i < DEPTH; i++) step_f(1'b0, 8'h00, 1'b1);
    check("full_rw_drained", f_if.empty_o, 1'b1);

    // simultaneous write and read while empty
    step_f(1'b1, 8'h33, 1'b1);
    check("empty_rw_empty", f_if.empty_o, 1'b0);
    check("empty_rw_data", f_if.rd_data_o, 8'h33);
    step_f(1'b0, 8'h00, 1'b1);

    // random traffic across several pointer wraps
    for (int i = 0; i < 120; i++)
      step_f(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    while (exp_q.size() > 0) step_f(1'b0, 8'h00, 1'b1);

    // registered read path
    step_r(1'b1, 8'h11, 1'b0);
    step_r(1'b1, 8'h22, 1'b0);
    step_r(1'b0, 8'h00, 1'b1);
    check("reg_first", r_rd_data, 8'h11);
    step_r(1'b0, 8'h00, 1'b0);
    step_r(1'b0, 8'h00, 1'b1);
    check("reg_second", r_rd_data, 8'h22);
    step_r(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 80; i++)
      step_r(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // asynchronous reset in the middle of a cycle with data stored
    while (exp_q.size() > 0) step_f(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step_f(1'b1, DW'(8'hC0 + i), 1'b0);
      step_r(1'b1, DW'(8'hD0 + i), 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_rq.delete();
    exp_rd = '0;
    check("arst_f_empty", f_if.empty_o, 1'b1);
    check("arst_f_full",  f_if.full_o, 1'b0);
    check("arst_r_empty", r_empty, 1'b1);
    check("arst_r_data",  r_rd_data, 8'h00);
`ifdef SYNC_FIFO_COUNT_EN
    check("arst_f_count", f_count, 0);
    check("arst_r_count", r_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step_f(1'b1, 8'h77, 1'b0);
    check("post_rst_data", f_if.rd_data_o, 8'h77);
    step_f(1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
